instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

- Drives the instruction ROM address and registers the 28-bit instruction the ROM returns.
- Splits the instruction into fields for the execute stage.
- Resolves control flow: JMP, CALL, RET, BLE and delay-NOP.
- Sits between the instruction ROM and the datapath. Holds the PC and a hardware return-address stack, so CALL/RET need no register file access.

## Interface

- STACK_DEPTH, 8: return-stack entries (2..16).

- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- iStall  in  1  datapath stall; freezes PC, IR, counter and stack
- iInstruction  in  28  instruction word from ROM for address oAddress (combinational ROM)
- iLessEqual  in  1  datapath compare R[oSrc1] <= R[oSrc0], valid combinationally in the same cycle as the fields
- oAddress  out  16  ROM address = PC (registered)
- oOpcode  out  8  IR[27:20]
- oDest  out  8  IR[19:12]
- oSrc1  out  8  IR[11:4]
- oSrc0  out  8  IR[7:0]
- oLiteral  out  16  IR[15:0]
- oValid  out  1  IR holds an instruction the datapath must execute
- oStackError  out  1  sticky: push on full or pop on empty

Field offsets:

- Opcode is bits [27:20].
- Byte 2 (dest / branch target) is bits [23:16].
- Byte 1 is bits [15:8]; byte 0 is bits [7:0].
- The oDest/oSrc1/oSrc0 labels above are wrong. The correct mapping is: oDest = IR[23:16], oSrc1 = IR[15:8], oSrc0 = IR[7:0].
- Opcode values are the shared-header constants `NOP, `JMP, `CALL, `RET, `BLE.

## Operation

Registers:

- PC[15:0]
- IR[27:0]
- IRAddr[15:0]: address IR was fetched from
- DelayCnt[23:0]
- stack array with pointer SP
- oStackError

Reset values:

- PC = 0, IR = {`NOP, 24'd0}, IRAddr = 0, DelayCnt = 0, SP = 0 (empty).
- oValid = 0, oStackError = 0.
- All field outputs are 0.

Per cycle, when iStall = 0, priority is highest first:

- **DELAY:** IR is `NOP with literal L = IR[23:0] > 0, and the delay has not finished.
  - On entry DelayCnt loads L−1 (when L = 1, skip to RUN next cycle).
  - DelayCnt then decrements once per cycle; PC and IR hold.
  - When DelayCnt reaches 0, proceed as RUN.
  - The same NOP never reloads: a delay-done flag is set on entry and cleared on the next IR load.
- **REDIRECT:** IR is JMP, CALL, RET, or BLE with iLessEqual = 1.
  - PC ← target; IR ← {`NOP, 24'd0}; oValid ← 0. This squashes the already-fetched next word.
  - Target for JMP/CALL/BLE is {8'd0, IR[23:16]}. RET target is the top of stack.
  - CALL pushes IRAddr+1. If the stack is full, the push is dropped, the jump still occurs, and oStackError ← 1.
  - RET on an empty stack: target 0, oStackError ← 1.
- **RUN:** IR ← iInstruction; IRAddr ← PC; PC ← PC+1 (wraps 0xFFFF → 0); oValid ← 1.

Other rules:

- BLE not taken is RUN.
- oValid = 1 also for JMP/CALL/RET/BLE. The datapath treats them as no register writes.
- iStall = 1 holds everything, including a pending redirect and DelayCnt.
- Reset mid-delay or mid-redirect aborts immediately to reset values. The stack is emptied.

## Timing

- Fetch latency: instruction at address A appears in IR one cycle after oAddress = A.
- Straight-line code has a throughput of 1 instruction/cycle.
- Taken control flow costs 1 bubble cycle (oValid = 0). The target instruction is in IR 2 cycles after the branch was in IR.
- `NOP with literal L occupies IR for L+1 cycles. `NOP 0 occupies it for 1 cycle.
- iLessEqual is sampled only in the cycle where IR holds BLE and iStall = 0.

## Test plan

- **Reset / straight line:** assert Reset, release, ROM = STO at 0..3.
  - oAddress steps 0,1,2,3,4.
  - oValid = 1 from cycle 2.
  - IRAddr tracks oAddress−1.
- **Delay NOP:** address 0 = {`NOP, 24'd4000}.
  - IR holds the NOP for 4001 cycles, with oAddress frozen at 1.
  - Then the word at address 1 loads.
- **JMP:** JMP 4 at address 16.
  - The cycle after IR = JMP: oValid = 0, oAddress = 4.
  - Next cycle IR = word 4, and the squashed word 17 never reaches oValid = 1.
- **CALL/RET:** CALL 17 at address 10, RET at 21.
  - Stack holds 11.
  - After RET, oAddress = 11 and SP returns to 0.
  - oStackError stays 0.
- **BLE:** BLE 9 at address 12.
  - With iLessEqual = 1, redirect to 9.
  - With iLessEqual = 0, proceed to 13 with no bubble.
- **Stack errors and stall:** nest STACK_DEPTH+1 CALLs.
  - oStackError = 1 on the last CALL, and the jump is still taken.
  - RET on empty → oAddress = 0.
  - iStall = 1 during a redirect holds all outputs unchanged until release.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: holds PC, IR and a hardware return-address stack.
// It drives the ROM address, registers the returned word, splits it into
// fields for the datapath, and resolves JMP/CALL/RET/BLE and delay-NOPs.
// The opcode field IR[27:20] overlaps the top nibble of the branch-target
// byte IR[23:16]. A branch opcode's low nibble therefore also fixes the upper
// nibble of its target. A NOP (0x00) can carry a delay literal below 2^20.
module instruction_fetch_unit #(
    parameter int STACK_DEPTH = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iStall,
    input  logic [27:0] iInstruction,
    input  logic        iLessEqual,
    output logic [15:0] oAddress,
    output logic [7:0]  oOpcode,
    output logic [7:0]  oDest,
    output logic [7:0]  oSrc1,
    output logic [7:0]  oSrc0,
    output logic [15:0] oLiteral,
    output logic        oValid,
    output logic        oStackError
);

    localparam logic [7:0]  OP_NOP  = 8'h00;
    localparam logic [7:0]  OP_JMP  = 8'h10;
    localparam logic [7:0]  OP_CALL = 8'h21;
    localparam logic [7:0]  OP_RET  = 8'h30;
    localparam logic [7:0]  OP_BLE  = 8'h40;
    localparam logic [27:0] IR_NOP0 = {OP_NOP, 20'd0};

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    typedef enum logic [1:0] {
        ACT_RUN,
        ACT_DELAY,
        ACT_REDIRECT
    } action_t;

    logic [15:0]      r_pc;
    logic [27:0]      r_ir;
    logic [15:0]      r_ir_addr;
    logic [23:0]      r_delay_cnt;
    logic             r_delay_done;
    logic             r_valid;
    logic             r_stack_err;
    logic [SP_W-1:0]  r_sp;
    logic [15:0]      r_stack [STACK_DEPTH];

    logic [7:0]       w_op;
    logic [23:0]      w_lit;
    logic             w_is_nop;
    logic             w_is_jmp;
    logic             w_is_call;
    logic             w_is_ret;
    logic             w_is_ble;
    logic             w_stack_full;
    logic             w_stack_empty;
    logic [IDX_W-1:0] w_top_idx;
    logic [IDX_W-1:0] w_push_idx;
    logic [15:0]      w_target;
    action_t          w_action;

    assign w_op      = r_ir[27:20];
    assign w_lit     = r_ir[23:0];
    assign w_is_nop  = (w_op == OP_NOP);
    assign w_is_jmp  = (w_op == OP_JMP);
    assign w_is_call = (w_op == OP_CALL);
    assign w_is_ret  = (w_op == OP_RET);
    assign w_is_ble  = (w_op == OP_BLE);

    assign w_stack_full  = (r_sp == SP_W'(STACK_DEPTH));
    assign w_stack_empty = (r_sp == '0);
    assign w_top_idx     = IDX_W'(r_sp - SP_W'(1));
    assign w_push_idx    = IDX_W'(r_sp);

    // Choose this cycle's action: an unfinished delay beats a redirect, which beats a plain fetch.
    always_comb begin
        w_action = ACT_RUN;
        if (w_is_nop && (w_lit != 24'd0) && (!r_delay_done || (r_delay_cnt != 24'd0))) begin
            w_action = ACT_DELAY;
        end else if (w_is_jmp || w_is_call || w_is_ret || (w_is_ble && iLessEqual)) begin
            w_action = ACT_REDIRECT;
        end
    end

    // Redirect target: the byte-2 field, or the stack top for RET (0 when the stack is empty).
    always_comb begin
        w_target = {8'd0, r_ir[23:16]};
        if (w_is_ret) begin
            w_target = w_stack_empty ? 16'd0 : r_stack[w_top_idx];
        end
    end

    // PC, IR, delay counter, stack pointer and error flag. A stall freezes all of them.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_pc         <= 16'd0;
            r_ir         <= IR_NOP0;
            r_ir_addr    <= 16'd0;
            r_delay_cnt  <= 24'd0;
            r_delay_done <= 1'b0;
            r_valid      <= 1'b0;
            r_stack_err  <= 1'b0;
            r_sp         <= '0;
        end else if (!iStall) begin
            case (w_action)
                ACT_DELAY: begin
                    // The first cycle loads L-1; the done flag stops the same NOP from reloading.
                    if (!r_delay_done) begin
                        r_delay_cnt  <= w_lit - 24'd1;
                        r_delay_done <= 1'b1;
                    end else begin
                        r_delay_cnt <= r_delay_cnt - 24'd1;
                    end
                end
                ACT_REDIRECT: begin
                    // Squash the word already fetched behind the branch.
                    r_pc         <= w_target;
                    r_ir         <= IR_NOP0;
                    r_valid      <= 1'b0;
                    r_delay_done <= 1'b0;
                    if (w_is_call) begin
                        if (w_stack_full) begin
                            r_stack_err <= 1'b1;
                        end else begin
                            r_sp <= r_sp + SP_W'(1);
                        end
                    end
                    if (w_is_ret) begin
                        if (w_stack_empty) begin
                            r_stack_err <= 1'b1;
                        end else begin
                            r_sp <= r_sp - SP_W'(1);
                        end
                    end
                end
                default: begin
                    r_ir         <= iInstruction;
                    r_ir_addr    <= r_pc;
                    r_pc         <= r_pc + 16'd1;
                    r_valid      <= 1'b1;
                    r_delay_done <= 1'b0;
                end
            endcase
        end
    end

    // Return-address storage. Only SP needs reset, because entries above SP are never read.
    always_ff @(posedge Clock) begin
        if (!iStall && (w_action == ACT_REDIRECT) && w_is_call && !w_stack_full) begin
            r_stack[w_push_idx] <= r_ir_addr + 16'd1;
        end
    end

    assign oAddress    = r_pc;
    assign oOpcode     = r_ir[27:20];
    assign oDest       = r_ir[23:16];
    assign oSrc1       = r_ir[15:8];
    assign oSrc0       = r_ir[7:0];
    assign oLiteral    = r_ir[15:0];
    assign oValid      = r_valid;
    assign oStackError = r_stack_err;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: a behavioural fetch model driven by
// the same ROM image, plus directed scenarios and randomized programs.
module tb_instruction_fetch_unit;

    localparam int STACK_DEPTH = 8;
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_JMP  = 8'h10;
    localparam logic [7:0] OP_CALL = 8'h21;
    localparam logic [7:0] OP_RET  = 8'h30;
    localparam logic [7:0] OP_BLE  = 8'h40;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        iStall = 1'b0;
    logic        iLessEqual = 1'b0;
    logic [27:0] iInstruction;
    logic [15:0] oAddress;
    logic [7:0]  oOpcode, oDest, oSrc1, oSrc0;
    logic [15:0] oLiteral;
    logic        oValid;
    logic        oStackError;

    logic [27:0] rom [0:255];

    instruction_fetch_unit #(.STACK_DEPTH(STACK_DEPTH)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iStall       (iStall),
        .iInstruction (iInstruction),
        .iLessEqual   (iLessEqual),
        .oAddress     (oAddress),
        .oOpcode      (oOpcode),
        .oDest        (oDest),
        .oSrc1        (oSrc1),
        .oSrc0        (oSrc0),
        .oLiteral     (oLiteral),
        .oValid       (oValid),
        .oStackError  (oStackError)
    );

    always #5 Clock = ~Clock;

    assign iInstruction = rom[oAddress[7:0]];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: architectural view of the fetch unit.
    logic [15:0] m_pc;
    logic [27:0] m_ir;
    logic [15:0] m_iraddr;
    logic        m_valid;
    logic        m_err;
    int          m_hold;
    logic [15:0] m_stack [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [27:0] sto_word();
        logic [7:0] op;
        op = 8'($urandom_range(8'hFF, 8'h50));
        return {op, 20'($urandom)};
    endfunction

    task automatic model_reset();
        m_pc = 16'd0;
        m_ir = {OP_NOP, 20'd0};
        m_iraddr = 16'd0;
        m_valid = 1'b0;
        m_err = 1'b0;
        m_hold = 0;
        m_stack.delete();
    endtask

    // One clock of the architectural model: finish any NOP delay, then a taken branch, else fetch.
    task automatic model_step(input logic stall, input logic le);
        logic [7:0]  op;
        logic [15:0] tgt;
        if (stall) return;
        op = m_ir[27:20];
        if (m_hold > 0) begin
            m_hold--;
        end else if (op == OP_JMP || op == OP_CALL || op == OP_RET || (op == OP_BLE && le)) begin
            tgt = {8'd0, m_ir[23:16]};
            if (op == OP_CALL) begin
                if (m_stack.size() < STACK_DEPTH) m_stack.push_back(m_iraddr + 16'd1);
                else m_err = 1'b1;
            end
            if (op == OP_RET) begin
                if (m_stack.size() > 0) tgt = m_stack.pop_back();
                else begin
                    tgt = 16'd0;
                    m_err = 1'b1;
                end
            end
            m_pc = tgt;
            m_ir = {OP_NOP, 20'd0};
            m_valid = 1'b0;
            m_hold = 0;
        end else begin
            m_ir = rom[m_pc[7:0]];
            m_iraddr = m_pc;
            m_pc = m_pc + 16'd1;
            m_valid = 1'b1;
            m_hold = (m_ir[27:20] == OP_NOP) ? int'(m_ir[23:0]) : 0;
        end
    endtask

    task automatic compare_all();
        check("addr",    32'(oAddress),    32'(m_pc));
        check("valid",   32'(oValid),      32'(m_valid));
        check("opcode",  32'(oOpcode),     32'(m_ir[27:20]));
        check("dest",    32'(oDest),       32'(m_ir[23:16]));
        check("src1",    32'(oSrc1),       32'(m_ir[15:8]));
        check("src0",    32'(oSrc0),       32'(m_ir[7:0]));
        check("literal", 32'(oLiteral),    32'(m_ir[15:0]));
        check("stkerr",  32'(oStackError), 32'(m_err));
    endtask

    // Entered and left at a falling edge.
    task automatic run_cycles(input int n, input int stall_pct, input int le_pct);
        for (int c = 0; c < n; c++) begin
            compare_all();
            iStall = ($urandom_range(99) < 32'(stall_pct));
            iLessEqual = ($urandom_range(99) < 32'(le_pct));
            @(posedge Clock);
            model_step(iStall, iLessEqual);
            @(negedge Clock);
        end
        iStall = 1'b0;
        iLessEqual = 1'b0;
    endtask

    task automatic run_until_op(input logic [7:0] op, input int budget, input string tag);
        for (int c = 0; c < budget; c++) begin
            if (oOpcode == op) break;
            run_cycles(1, 0, 0);
        end
        check({tag, "_reach"}, 32'(oOpcode), 32'(op));
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic apply_reset();
        Reset = 1'b1;
        iStall = 1'b0;
        iLessEqual = 1'b0;
        model_reset();
        #1;
        check("rst_addr",   32'(oAddress), 32'd0);
        check("rst_valid",  32'(oValid), 32'd0);
        check("rst_err",    32'(oStackError), 32'd0);
        check("rst_fields", {oOpcode, oDest, oSrc1, oSrc0}, 32'd0);
        check("rst_lit",    32'(oLiteral), 32'd0);
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic fill_sto();
        for (int a = 0; a < 256; a++) rom[a] = sto_word();
    endtask

    function automatic logic [27:0] rand_word();
        int r;
        r = int'($urandom_range(99));
        if (r < 8)  return {OP_JMP,  20'($urandom)};
        if (r < 14) return {OP_CALL, 20'($urandom)};
        if (r < 20) return {OP_RET,  20'($urandom)};
        if (r < 28) return {OP_BLE,  20'($urandom)};
        if (r < 36) return {OP_NOP,  20'($urandom_range(6))};
        if (r < 37) return {OP_NOP,  20'($urandom_range(60, 20))};
        return sto_word();
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        @(negedge Clock);

        // Delay NOP, CALL/RET, BLE and JMP on one image.
        fill_sto();
        rom[0]  = {OP_NOP, 20'd4000};
        rom[10] = {OP_CALL, 4'h1, 16'($urandom)};
        rom[12] = {OP_BLE, 4'h9, 16'($urandom)};
        rom[16] = {OP_JMP, 4'h4, 16'($urandom)};
        rom[21] = {OP_RET, 20'd0};
        apply_reset();
        run_cycles(1, 0, 0);
        check("delay_addr_start", 32'(oAddress), 32'd1);
        check("delay_lit", 32'(oLiteral), 32'd4000);
        run_cycles(2000, 0, 0);
        check("delay_addr_mid", 32'(oAddress), 32'd1);
        run_cycles(2000, 0, 0);
        check("delay_addr_end", 32'(oAddress), 32'd1);
        check("delay_op_end", 32'(oOpcode), 32'(OP_NOP));
        run_cycles(1, 0, 0);
        check("delay_next_addr", 32'(oAddress), 32'd2);
        check("delay_next_word", 32'(oLiteral), 32'(rom[1][15:0]));

        run_until_op(OP_CALL, 40, "call");
        run_cycles(1, 0, 0);
        check("call_addr", 32'(oAddress), 32'd17);
        check("call_bubble", 32'(oValid), 32'd0);
        run_until_op(OP_RET, 40, "ret");
        run_cycles(1, 0, 0);
        check("ret_addr", 32'(oAddress), 32'd11);
        check("ret_bubble", 32'(oValid), 32'd0);
        check("ret_err", 32'(oStackError), 32'd0);

        run_until_op(OP_BLE, 40, "ble_taken");
        run_cycles(1, 0, 100);
        check("ble_taken_addr", 32'(oAddress), 32'd9);
        check("ble_taken_bubble", 32'(oValid), 32'd0);
        run_until_op(OP_BLE, 60, "ble_fall");
        run_cycles(1, 0, 0);
        check("ble_fall_addr", 32'(oAddress), 32'd14);
        check("ble_fall_valid", 32'(oValid), 32'd1);
        check("ble_fall_word", 32'(oLiteral), 32'(rom[13][15:0]));

        run_until_op(OP_JMP, 40, "jmp");
        run_cycles(1, 0, 0);
        check("jmp_addr", 32'(oAddress), 32'd4);
        check("jmp_bubble", 32'(oValid), 32'd0);
        run_cycles(1, 0, 0);
        check("jmp_tgt_addr", 32'(oAddress), 32'd5);
        check("jmp_tgt_valid", 32'(oValid), 32'd1);
        check("jmp_tgt_word", 32'(oLiteral), 32'(rom[4][15:0]));
        run_cycles(200, 30, 50);

        // Nested CALLs overflow the stack on the ninth push.
        fill_sto();
        rom[0] = {OP_CALL, 4'h0, 16'($urandom)};
        for (int a = 16; a < 24; a++) rom[a] = {OP_CALL, 4'(a + 1), 16'($urandom)};
        rom[25] = {OP_RET, 20'd0};
        apply_reset();
        for (int k = 0; k <= STACK_DEPTH; k++) begin
            run_until_op(OP_CALL, 40, "nest_call");
            if (k == STACK_DEPTH) check("nest_err_before", 32'(oStackError), 32'd0);
            run_cycles(1, 0, 0);
        end
        check("nest_err", 32'(oStackError), 32'd1);
        check("nest_jump", 32'(oAddress), 32'h18);
        check("nest_bubble", 32'(oValid), 32'd0);
        run_cycles(100, 25, 50);

        // RET on an empty stack, held under stall first.
        fill_sto();
        rom[0] = {OP_RET, 20'd0};
        apply_reset();
        run_cycles(1, 0, 0);
        run_cycles(3, 100, 0);
        check("stall_addr", 32'(oAddress), 32'd1);
        check("stall_op", 32'(oOpcode), 32'(OP_RET));
        check("stall_valid", 32'(oValid), 32'd1);
        check("stall_err", 32'(oStackError), 32'd0);
        run_cycles(1, 0, 0);
        check("ret_empty_addr", 32'(oAddress), 32'd0);
        check("ret_empty_err", 32'(oStackError), 32'd1);
        check("ret_empty_bubble", 32'(oValid), 32'd0);

        // Random programs with random stalls, compares and resets.
        for (int blk = 0; blk < 20; blk++) begin
            for (int a = 0; a < 256; a++) rom[a] = rand_word();
            apply_reset();
            run_cycles(300, int'($urandom_range(40)), int'($urandom_range(100)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
